// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache-to-SRAM sequencer.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam int READ_BEATS  = 4;
  localparam int WRITE_BEATS = 2;
  localparam int SRAM_AW     = 18;
  localparam int SRAM_DW     = 16;
  localparam int BEAT_W      = 2;
  localparam int WAIT_W      = 3;
  localparam int LINE_W      = READ_BEATS * SRAM_DW;

endpackage

// File: rtl/sram_beat_timer.sv
// Wait-state and beat counters for one SRAM transfer type.
module sram_beat_timer
  import cache_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int BEATS       = READ_BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  output logic [BEAT_W-1:0] beat,
  output logic              beat_last,
  output logic              xfer_last
);

  logic [WAIT_W-1:0] wait_cnt;

  assign beat_last = en && (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
  assign xfer_last = beat_last && (beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (en) begin
      if (beat_last) begin
        wait_cnt <= '0;
        beat     <= xfer_last ? '0 : beat + 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_sram_ctrl.sv
// Cache line-fill / write-through sequencer for a 16-bit SRAM.
// Optional transfer counters when CACHE_CTRL_STATS_EN is defined.
module cache_sram_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en_n,
  input  logic               wr_en_n,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic               pause,
  output logic               line_valid,
  output logic [LINE_W-1:0]  line_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]        stat_fills,
  output logic [31:0]        stat_writes
`endif
);

  state_t state, state_next;
  logic   fill_q;

  logic [BEAT_W-1:0] rd_beat, wr_beat;
  logic rd_beat_last, rd_xfer_last;
  logic wr_beat_last, wr_xfer_last;
  logic rd_start, wr_start;
  logic req;

  assign req      = !rd_en_n || !wr_en_n;
  assign rd_start = (state == IDLE) && (state_next == READ);
  assign wr_start = (state == IDLE) && (state_next == WRITE);

  sram_beat_timer #(.WAIT_CYCLES(WAIT_CYCLES), .BEATS(READ_BEATS)) u_rd_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (rd_start),
    .en        (state == READ),
    .beat      (rd_beat),
    .beat_last (rd_beat_last),
    .xfer_last (rd_xfer_last)
  );

  sram_beat_timer #(.WAIT_CYCLES(WAIT_CYCLES), .BEATS(WRITE_BEATS)) u_wr_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (wr_start),
    .en        (state == WRITE),
    .beat      (wr_beat),
    .beat_last (wr_beat_last),
    .xfer_last (wr_xfer_last)
  );

  // Write wins a simultaneous request; the held read is taken on a later IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!wr_en_n)      state_next = WRITE;
        else if (!rd_en_n) state_next = READ;
      end
      READ:    if (rd_xfer_last) state_next = DONE;
      WRITE:   if (wr_xfer_last) state_next = DONE;
      DONE:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pause       = 1'b0;
    line_valid  = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    case (state)
      // Freeze starts combinationally so the pipeline stalls in the request cycle.
      IDLE: pause = req;
      READ: begin
        pause     = 1'b1;
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_addr = {address[18:3], rd_beat};
      end
      WRITE: begin
        pause       = 1'b1;
        sram_ce_n   = 1'b0;
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_addr   = {address[18:2], wr_beat[0]};
        sram_dq_out = wr_beat[0] ? wdata[31:16] : wdata[15:0];
      end
      DONE: begin
        pause      = 1'b1;
        line_valid = fill_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fill_q    <= 1'b0;
      line_data <= '0;
    end else begin
      state <= state_next;
      if (rd_start)      fill_q <= 1'b1;
      else if (wr_start) fill_q <= 1'b0;
      if (state == READ && rd_beat_last)
        line_data[{rd_beat, 4'b0000} +: SRAM_DW] <= sram_dq_in;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fills  <= '0;
      stat_writes <= '0;
    end else if (state == DONE) begin
      if (fill_q) stat_fills  <= stat_fills + 1'b1;
      else        stat_writes <= stat_writes + 1'b1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{address[31:19], address[1:0], wr_beat[1], wr_beat_last};

endmodule

// File: tb/tb_cache_sram_ctrl.sv
// Scoreboard bench for cache_sram_ctrl at WAIT_CYCLES=1 and WAIT_CYCLES=3.
module tb_cache_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_en_n, wr_en_n, rd_en_n3, wr_en_n3;
  logic [31:0] address, wdata;

  logic        pause, line_valid, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [63:0] line_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  logic        pause3, line_valid3, sram_dq_oe3, sram_ce_n3, sram_oe_n3, sram_we_n3;
  logic [63:0] line_data3;
  logic [17:0] sram_addr3;
  logic [15:0] sram_dq_out3, sram_dq_in3;

  logic [15:0] mem [0:255];
  assign sram_dq_in  = mem[sram_addr[7:0]];
  assign sram_dq_in3 = mem[sram_addr3[7:0]];

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] stat_fills, stat_writes, stat_fills3, stat_writes3;
`endif

  cache_sram_ctrl #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .rd_en_n(rd_en_n), .wr_en_n(wr_en_n),
    .address(address), .wdata(wdata), .pause(pause), .line_valid(line_valid),
    .line_data(line_data), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
`ifdef CACHE_CTRL_STATS_EN
    , .stat_fills(stat_fills), .stat_writes(stat_writes)
`endif
  );

  cache_sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .rd_en_n(rd_en_n3), .wr_en_n(wr_en_n3),
    .address(address), .wdata(wdata), .pause(pause3), .line_valid(line_valid3),
    .line_data(line_data3), .sram_addr(sram_addr3), .sram_dq_out(sram_dq_out3),
    .sram_dq_oe(sram_dq_oe3), .sram_dq_in(sram_dq_in3), .sram_ce_n(sram_ce_n3),
    .sram_oe_n(sram_oe_n3), .sram_we_n(sram_we_n3)
`ifdef CACHE_CTRL_STATS_EN
    , .stat_fills(stat_fills3), .stat_writes(stat_writes3)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] val;
  } ev_t;

  ev_t q0[$];
  ev_t q3[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  // kind 0 = read beat (addr), 1 = write beat ({addr,oe,dq}), 2 = line_valid (data)
  task automatic expect_ev(int inst, int kind, int c, logic [63:0] v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    if (inst == 0) q0.push_back(e);
    else           q3.push_back(e);
  endtask

  task automatic observe(int inst, int kind, logic [63:0] v);
    ev_t   e;
    string nm;
    nm = (kind == 0) ? "rd_beat" : (kind == 1) ? "wr_beat" : "line";
    if ((inst == 0 && q0.size() == 0) || (inst == 1 && q3.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_%s inst%0d @cyc %0d: got %h required no event", nm, inst, cyc, v);
      return;
    end
    e = (inst == 0) ? q0.pop_front() : q3.pop_front();
    check($sformatf("%s_kind_cycle inst%0d", nm, inst), {kind, cyc}, {e.kind, e.cyc});
    check($sformatf("%s_value inst%0d", nm, inst), v, e.val);
  endtask

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_oe_n) observe(0, 0, 64'(sram_addr));
    if (!sram_ce_n && !sram_we_n) observe(0, 1, 64'({sram_addr, sram_dq_oe, sram_dq_out}));
    if (line_valid)               observe(0, 2, line_data);
    if (!sram_ce_n3 && !sram_oe_n3) observe(1, 0, 64'(sram_addr3));
    if (!sram_ce_n3 && !sram_we_n3) observe(1, 1, 64'({sram_addr3, sram_dq_oe3, sram_dq_out3}));
    if (line_valid3)                observe(1, 2, line_data3);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(string tag);
    @(negedge clk);
    check({tag, "_pause_lv"}, {pause, line_valid}, 2'b00);
    check({tag, "_strobes"}, {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    check({tag, "_addr_dq"}, {sram_addr, sram_dq_out}, '0);
    check({tag, "_line"}, line_data, 64'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_read(int inst, int c0, int w, logic [17:0] base, logic [63:0] line);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < w; j++)
        expect_ev(inst, 0, c0 + 1 + w * k + j, 64'(base + 18'(k)));
    expect_ev(inst, 2, c0 + 4 * w + 1, line);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 + 16'(i);
    mem[8'h84] = 16'h1111;
    mem[8'h85] = 16'h2222;
    mem[8'h86] = 16'h3333;
    mem[8'h87] = 16'h4444;
    rst = 1'b1; rd_en_n = 1'b1; wr_en_n = 1'b1; rd_en_n3 = 1'b1; wr_en_n3 = 1'b1;
    address = '0; wdata = '0;
    tick(3);
    check_reset("por");
    rst = 1'b0;
    tick(2);

    // Read miss W=1, request held low through ACK
    address = 32'h0000_0108; rd_en_n = 1'b0; c0 = cyc;
    expect_read(0, c0, 1, 18'h084, 64'h4444_3333_2222_1111);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("rd_pause_c%0d", i), pause, (i <= 5));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("held_req_no_ack_start", {sram_ce_n, pause}, 2'b11);
    rd_en_n = 1'b1;
    tick(3);

    // Write-through W=1
    address = 32'h0000_0204; wdata = 32'hDEAD_BEEF; wr_en_n = 1'b0; c0 = cyc;
    expect_ev(0, 1, c0 + 1, 64'({18'h102, 1'b1, 16'hBEEF}));
    expect_ev(0, 1, c0 + 2, 64'({18'h103, 1'b1, 16'hDEAD}));
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("wr_pause_c%0d", i), pause, (i <= 3));
      if (i == 3) wr_en_n = 1'b1;
      @(posedge clk); #1;
    end
    tick(2);

    // Simultaneous requests: write first, read after ACK
    address = 32'h0000_0208; wdata = 32'h1234_5678; rd_en_n = 1'b0; wr_en_n = 1'b0; c0 = cyc;
    expect_ev(0, 1, c0 + 1, 64'({18'h104, 1'b1, 16'h5678}));
    expect_ev(0, 1, c0 + 2, 64'({18'h105, 1'b1, 16'h1234}));
    expect_read(0, c0 + 5, 1, 18'h104, 64'h5A07_5A06_5A05_5A04);
    tick(3);
    wr_en_n = 1'b1;
    tick(7);
    rd_en_n = 1'b1;
    tick(4);

    // Read miss W=3 on the second instance
    address = 32'h0000_0108; rd_en_n3 = 1'b0; c0 = cyc;
    expect_read(1, c0, 3, 18'h084, 64'h4444_3333_2222_1111);
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      check($sformatf("w3_pause_c%0d", i), pause3, (i <= 13));
      if (i == 12) rd_en_n3 = 1'b1;
      @(posedge clk); #1;
    end
    tick(2);

    // Reset for 3 cycles in the middle of a read
    address = 32'h0000_0108; rd_en_n = 1'b0; c0 = cyc;
    expect_ev(0, 0, c0 + 1, 64'(18'h084));
    expect_ev(0, 0, c0 + 2, 64'(18'h085));
    tick(2);
    rst = 1'b1; rd_en_n = 1'b1;
    tick(1);
    check_reset("mid_rst_a");
    check_reset("mid_rst_b");
    rst = 1'b0;
    check_reset("post_rst");
    address = 32'h0000_0110; rd_en_n = 1'b0; c0 = cyc;
    expect_read(0, c0, 1, 18'h088, 64'h5A8B_5A8A_5A89_5A88);
    tick(5);
    rd_en_n = 1'b1;
    tick(4);

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q3_drained", 64'(q3.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
